// File: rtl/retospect_cfg_loader_if.sv
// rtl/retospect_cfg_loader_if.sv - byte stream interface feeding the scan-chain config loader
//
// Purpose: carries the configuration bitstream, one byte per handshake.
// Signals:
//   s_data  - bitstream byte, bit 0 is shifted onto the chain first
//   s_valid - source has a byte on s_data
//   s_ready - loader takes s_data on this cycle's rising edge
// Modports: master (bitstream source), slave (loader).
interface retospect_cfg_loader_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/retospect_cfg_loader.sv
// rtl/retospect_cfg_loader.sv - scan-chain configuration sequencer with CRC-8 readback
//
// Purpose: shifts a byte stream LSB-first onto the neurochip scan chain
// (clockbox followed by the cnb array), folds the old chain contents that come
// out of the tail into a CRC-8, then pulses reset_nn once to arm the network.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   start_i, abort_i  - begin a load (IDLE only) / cancel a load (LOAD, ARM)
//   s_if              - bitstream byte stream (slave side)
//   cfg_en_o,cfg_bs_o - chain config_en / bs_in, registered
//   cfg_bs_ret_i      - chain bs_out
//   nn_reset_o        - chain reset_nn, one-cycle registered pulse
//   busy_o, done_o    - not idle / one-cycle completion pulse
//   aborted_o         - sticky, cleared by the next accepted start
//   readback_crc_o    - CRC-8 (poly 0x07, init 0, MSB-first) of returned bits
//   bit_count_o       - bits shifted in the current or most recent load
module retospect_cfg_loader #(
  parameter int CHAIN_LEN = 352,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   abort_i,
  retospect_cfg_loader_if.slave  s_if,
  output logic                   cfg_en_o,
  output logic                   cfg_bs_o,
  input  logic                   cfg_bs_ret_i,
  output logic                   nn_reset_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   aborted_o,
  output logic [7:0]             readback_crc_o,
  output logic [CNT_W-1:0]       bit_count_o
);

  localparam logic [CNT_W-1:0] LEN = CNT_W'(CHAIN_LEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ARM  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [6:0]       shreg_q, shreg_d;   // bits of the current byte not yet presented
  logic [2:0]       rem_q, rem_d;       // count of those bits
  logic [CNT_W-1:0] acc_q, acc_d;       // bits accepted from the stream this load
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       crc_q, crc_d;
  logic             en_q, en_d;
  logic             bs_q, bs_d;
  logic             nn_q, nn_d;
  logic             done_q, done_d;
  logic             ab_q, ab_d;

  logic             s_ready;
  logic             handshake;
  logic [CNT_W-1:0] left;
  logic [3:0]       byte_bits;
  logic             crc_fb;
  logic [7:0]       crc_next;

  // rem_q==0 covers both "empty" and "presenting the last bit of a byte",
  // so the next byte is taken exactly when the current one runs out.
  assign left      = LEN - acc_q;
  assign byte_bits = (left >= CNT_W'(8)) ? 4'd8 : left[3:0];
  assign s_ready   = (state_q == S_LOAD) && (acc_q < LEN) && (rem_q == 3'd0);
  assign handshake = s_if.s_valid && s_ready;

  assign crc_fb   = crc_q[7] ^ cfg_bs_ret_i;
  assign crc_next = {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    en_d    = en_q;
    bs_d    = bs_q;
    nn_d    = 1'b0;
    done_d  = 1'b0;
    ab_d    = ab_q;

    case (state_q)
      S_IDLE: begin
        en_d = 1'b0;
        if (start_i) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          crc_d   = 8'h00;
          acc_d   = '0;
          rem_d   = 3'd0;
          ab_d    = 1'b0;
        end
      end

      S_LOAD: begin
        // The chain shifts on every edge where cfg_en is high; the tail bit
        // captured on that same edge is the one that falls off the chain.
        if (en_q) begin
          cnt_d = cnt_q + CNT_W'(1);
          crc_d = crc_next;
        end
        if (rem_q != 3'd0) begin
          en_d    = 1'b1;
          bs_d    = shreg_q[0];
          shreg_d = {1'b0, shreg_q[6:1]};
          rem_d   = rem_q - 3'd1;
        end else if (handshake) begin
          // A short final byte only contributes its low bits.
          en_d    = 1'b1;
          bs_d    = s_if.s_data[0];
          shreg_d = s_if.s_data[7:1];
          rem_d   = 3'(byte_bits - 4'd1);
          acc_d   = acc_q + CNT_W'(byte_bits);
        end else begin
          en_d = 1'b0;
        end
        if (en_q && (cnt_q == LEN - CNT_W'(1))) begin
          state_d = S_ARM;
          en_d    = 1'b0;
          nn_d    = 1'b1;
        end
        if (abort_i) begin
          state_d = S_IDLE;
          en_d    = 1'b0;
          nn_d    = 1'b0;
          rem_d   = 3'd0;
          ab_d    = 1'b1;
        end
      end

      S_ARM: begin
        en_d = 1'b0;
        if (abort_i) begin
          state_d = S_IDLE;
          ab_d    = 1'b1;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end

      S_DONE: begin
        en_d    = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      crc_q   <= 8'h00;
      en_q    <= 1'b0;
      bs_q    <= 1'b0;
      nn_q    <= 1'b0;
      done_q  <= 1'b0;
      ab_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      en_q    <= en_d;
      bs_q    <= bs_d;
      nn_q    <= nn_d;
      done_q  <= done_d;
      ab_q    <= ab_d;
    end
  end

  assign s_if.s_ready   = s_ready;
  assign cfg_en_o       = en_q;
  assign cfg_bs_o       = bs_q;
  assign nn_reset_o     = nn_q;
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = done_q;
  assign aborted_o      = ab_q;
  assign readback_crc_o = crc_q;
  assign bit_count_o    = cnt_q;

endmodule

// File: tb/tb_retospect_cfg_loader.sv
// tb/tb_retospect_cfg_loader.sv - randomized self-checking bench for the scan-chain config loader
module tb_retospect_cfg_loader;
  localparam int LA = 352;
  localparam int LB = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic a_start, a_abort, a_en, a_bs, a_ret, a_nn, a_busy, a_done, a_ab;
  logic [7:0] a_crc;
  logic [15:0] a_cnt;
  logic b_start, b_abort, b_en, b_bs, b_ret, b_nn, b_busy, b_done, b_ab;
  logic [7:0] b_crc;
  logic [15:0] b_cnt;

  retospect_cfg_loader_if a_if ();
  retospect_cfg_loader_if b_if ();

  retospect_cfg_loader #(.CHAIN_LEN(LA), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(a_start), .abort_i(a_abort), .s_if(a_if),
    .cfg_en_o(a_en), .cfg_bs_o(a_bs), .cfg_bs_ret_i(a_ret), .nn_reset_o(a_nn),
    .busy_o(a_busy), .done_o(a_done), .aborted_o(a_ab), .readback_crc_o(a_crc),
    .bit_count_o(a_cnt));

  retospect_cfg_loader #(.CHAIN_LEN(LB), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(b_start), .abort_i(b_abort), .s_if(b_if),
    .cfg_en_o(b_en), .cfg_bs_o(b_bs), .cfg_bs_ret_i(b_ret), .nn_reset_o(b_nn),
    .busy_o(b_busy), .done_o(b_done), .aborted_o(b_ab), .readback_crc_o(b_crc),
    .bit_count_o(b_cnt));

  // Scan-chain models: bs_in enters at bit 0, bs_out is the top bit.
  logic [LA-1:0] chain_a = '0;
  logic [LB-1:0] chain_b = '0;
  assign a_ret = chain_a[LA-1];
  assign b_ret = chain_b[LB-1];
  always @(posedge clk) begin
    if (a_en) chain_a <= {chain_a[LA-2:0], a_bs};
    if (b_en) chain_b <= {chain_b[LB-2:0], b_bs};
  end

  int checks = 0;
  int errors = 0;

  // Observation of what each loader drove onto its chain.
  int cyc = 0;
  int en_a = 0, nn_a = 0, done_a = 0, both_a = 0, first_a = -1, last_a = -1, nn_cyc_a = 0, done_cyc_a = 0;
  int en_b = 0, nn_b = 0, done_b = 0, both_b = 0;
  bit bits_a[$];
  bit bits_b[$];
  always @(posedge clk) begin
    cyc++;
    if (a_en) begin
      en_a++;
      bits_a.push_back(a_bs);
      if (first_a < 0) first_a = cyc;
      last_a = cyc;
    end
    if (a_nn) begin nn_a++; nn_cyc_a = cyc; end
    if (a_done) begin done_a++; done_cyc_a = cyc; end
    if (a_en && a_nn) both_a++;
    if (b_en) begin en_b++; bits_b.push_back(b_bs); end
    if (b_nn) nn_b++;
    if (b_done) done_b++;
    if (b_en && b_nn) both_b++;
  end

  // Reference model: the bit stream a load should produce, and the CRC of a bit sequence.
  function automatic void expand(input logic [7:0] by[$], input int len, output bit q[$]);
    q.delete();
    foreach (by[i]) for (int k = 0; k < 8; k++) if (q.size() < len) q.push_back(by[i][k]);
  endfunction

  function automatic logic [7:0] crc8(input bit q[$]);
    logic [7:0] c = 8'h00;
    foreach (q[i]) begin
      if (c[7] ^ q[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  function automatic int diff_bits(input bit got[$], input bit exp[$]);
    int bad = (got.size() == exp.size()) ? 0 : 1;
    for (int i = 0; i < exp.size() && i < got.size(); i++) if (got[i] !== exp[i]) bad++;
    return bad;
  endfunction

  task automatic clear_mon();
    en_a = 0; nn_a = 0; done_a = 0; both_a = 0; first_a = -1; last_a = -1;
    en_b = 0; nn_b = 0; done_b = 0; both_b = 0;
    bits_a.delete(); bits_b.delete();
  endtask

  task automatic start_dut(input bit sel);
    if (sel) b_start = 1'b1; else a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0; b_start = 1'b0;
  endtask

  // Offers one byte; with gap>0 the stream is idle for gap cycles after the loader becomes ready.
  task automatic push(input bit sel, input logic [7:0] b, input int gap);
    int t;
    if (gap > 0) begin
      if (sel) b_if.s_valid = 1'b0; else a_if.s_valid = 1'b0;
      t = 0;
      while (!(sel ? b_if.s_ready : a_if.s_ready) && t < 50) begin @(negedge clk); t++; end
      repeat (gap) @(negedge clk);
    end
    if (sel) begin b_if.s_valid = 1'b1; b_if.s_data = b; end
    else begin a_if.s_valid = 1'b1; a_if.s_data = b; end
    t = 0;
    while (!(sel ? b_if.s_ready : a_if.s_ready) && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin
      checks++; errors++;
      $display("FAIL push_timeout dut=%0d s_ready stayed 0, required 1", sel);
    end
    @(negedge clk);
  endtask

  task automatic wait_done(input bit sel, input int budget);
    int t = 0;
    while (((sel ? done_b : done_a) == 0) && t < budget) begin @(negedge clk); t++; end
    if (t >= budget) begin
      checks++; errors++;
      $display("FAIL done_timeout dut=%0d no done within %0d cycles", sel, budget);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic load_a(input logic [7:0] by[$], input int gap_idx, input int gap);
    clear_mon();
    start_dut(1'b0);
    foreach (by[i]) push(1'b0, by[i], (i == gap_idx) ? gap : 0);
    a_if.s_valid = 1'b0;
    wait_done(1'b0, 100);
  endtask

  logic [7:0] bytes1[$];
  bit exp1[$];

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({a_en, a_bs, a_nn, a_busy, a_done, a_ab, a_crc, a_cnt, a_if.s_ready} !== '0) begin
      errors++;
      $display("FAIL reset_a en=%b nn=%b busy=%b done=%b ab=%b crc=%h cnt=%0d rdy=%b, required all 0",
               a_en, a_nn, a_busy, a_done, a_ab, a_crc, a_cnt, a_if.s_ready);
    end
    checks++;
    if ({b_en, b_bs, b_nn, b_busy, b_done, b_ab, b_crc, b_cnt, b_if.s_ready} !== '0) begin
      errors++;
      $display("FAIL reset_b en=%b busy=%b crc=%h cnt=%0d, required all 0", b_en, b_busy, b_crc, b_cnt);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_load();
    for (int i = 0; i < LA / 8; i++) bytes1.push_back(8'($urandom));
    expand(bytes1, LA, exp1);
    load_a(bytes1, -1, 0);
    checks++; if (en_a !== LA) begin errors++; $display("FAIL t1_en_cycles got %0d required %0d", en_a, LA); end
    checks++; if (last_a - first_a + 1 !== LA) begin errors++; $display("FAIL t1_gapfree span %0d required %0d", last_a - first_a + 1, LA); end
    checks++; if (nn_a !== 1 || nn_cyc_a !== last_a + 1) begin errors++; $display("FAIL t1_nn_reset pulses=%0d at %0d required 1 at %0d", nn_a, nn_cyc_a, last_a + 1); end
    checks++; if (done_a !== 1 || done_cyc_a !== nn_cyc_a + 1) begin errors++; $display("FAIL t1_done pulses=%0d at %0d required 1 at %0d", done_a, done_cyc_a, nn_cyc_a + 1); end
    checks++; if (both_a !== 0) begin errors++; $display("FAIL t1_en_and_nn overlap=%0d required 0", both_a); end
    checks++; if (a_cnt !== 16'(LA)) begin errors++; $display("FAIL t1_bit_count got %0d required %0d", a_cnt, LA); end
    checks++; if (a_crc !== 8'h00) begin errors++; $display("FAIL t1_crc got %h required 00", a_crc); end
    checks++; if (diff_bits(bits_a, exp1) !== 0) begin errors++; $display("FAIL t1_bits bad=%0d required 0", diff_bits(bits_a, exp1)); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL t1_busy got %b required 0", a_busy); end
  endtask

  task automatic test_repeat();
    logic [7:0] c_exp = crc8(exp1);
    int bad = 0;
    load_a(bytes1, -1, 0);
    checks++; if (a_crc !== c_exp) begin errors++; $display("FAIL t2_crc got %h required %h", a_crc, c_exp); end
    for (int i = 0; i < LA; i++) if (chain_a[LA-1-i] !== exp1[i]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL t2_chain_contents bad=%0d required 0", bad); end
    checks++; if (a_cnt !== 16'(LA) || done_a !== 1) begin errors++; $display("FAIL t2_count cnt=%0d done=%0d required %0d 1", a_cnt, done_a, LA); end
  endtask

  task automatic test_short_chain();
    bit exp3[$] = '{1, 0, 1, 0, 0, 1, 0, 1, 1, 1, 1, 1};
    int rdy_hi = 0;
    int t = 0;
    clear_mon();
    start_dut(1'b1);
    push(1'b1, 8'hA5, 0);
    push(1'b1, 8'hFF, 0);
    // Keep offering data: the loader must refuse it once the chain length is reached.
    while (done_b == 0 && t < 40) begin
      if (b_if.s_ready) rdy_hi++;
      @(negedge clk); t++;
    end
    b_if.s_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rdy_hi !== 0) begin errors++; $display("FAIL t3_ready_after_2nd ready cycles=%0d required 0", rdy_hi); end
    checks++; if (diff_bits(bits_b, exp3) !== 0) begin errors++; $display("FAIL t3_bits bad=%0d size=%0d required 0 size 12", diff_bits(bits_b, exp3), bits_b.size()); end
    checks++; if (b_cnt !== 16'(LB) || en_b !== LB) begin errors++; $display("FAIL t3_bit_count cnt=%0d en=%0d required %0d", b_cnt, en_b, LB); end
    checks++; if (nn_b !== 1 || done_b !== 1 || both_b !== 0) begin errors++; $display("FAIL t3_pulses nn=%0d done=%0d overlap=%0d required 1 1 0", nn_b, done_b, both_b); end
  endtask

  task automatic test_stall();
    logic [7:0] by[$];
    bit ex[$];
    logic [7:0] c_exp = crc8(exp1);
    for (int i = 0; i < LA / 8; i++) by.push_back(8'($urandom));
    expand(by, LA, ex);
    load_a(by, 3, 5);
    checks++; if (en_a !== LA) begin errors++; $display("FAIL t4_en_cycles got %0d required %0d", en_a, LA); end
    checks++; if (last_a - first_a + 1 !== LA + 5) begin errors++; $display("FAIL t4_stall_span got %0d required %0d", last_a - first_a + 1, LA + 5); end
    checks++; if (diff_bits(bits_a, ex) !== 0) begin errors++; $display("FAIL t4_bits bad=%0d required 0", diff_bits(bits_a, ex)); end
    checks++; if (a_crc !== c_exp) begin errors++; $display("FAIL t4_crc got %h required %h", a_crc, c_exp); end
  endtask

  task automatic test_abort();
    int t = 0;
    bit prev = 1'b0;
    clear_mon();
    start_dut(1'b0);
    a_if.s_valid = 1'b1;
    a_if.s_data = 8'($urandom);
    while (t < 400) begin
      if (prev) a_if.s_data = 8'($urandom);
      prev = a_if.s_ready;
      if (a_en && a_cnt == 16'd99) begin a_abort = 1'b1; break; end
      @(negedge clk); t++;
    end
    @(negedge clk);
    a_abort = 1'b0;
    checks++; if (a_en !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL t5_stop en=%b busy=%b required 0 0", a_en, a_busy); end
    checks++; if (a_ab !== 1'b1) begin errors++; $display("FAIL t5_aborted got %b required 1", a_ab); end
    checks++; if (a_cnt !== 16'd100 || en_a !== 100) begin errors++; $display("FAIL t5_bit_count cnt=%0d en=%0d required 100", a_cnt, en_a); end
    a_if.s_valid = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (nn_a !== 0 || done_a !== 0 || en_a !== 100) begin errors++; $display("FAIL t5_no_pulses nn=%0d done=%0d en=%0d required 0 0 100", nn_a, done_a, en_a); end
    start_dut(1'b0);
    checks++; if (a_ab !== 1'b0 || a_busy !== 1'b1) begin errors++; $display("FAIL t5_restart aborted=%b busy=%b required 0 1", a_ab, a_busy); end
  endtask

  task automatic test_reset_mid_load();
    logic [LA-1:0] snap;
    bit ret[$];
    logic [7:0] by[$];
    bit ex[$];
    logic [7:0] c_exp;
    // Continues the load started at the end of the abort scenario.
    for (int i = 0; i < 5; i++) push(1'b0, 8'($urandom), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_en, a_bs, a_nn, a_busy, a_done, a_ab, a_crc, a_cnt, a_if.s_ready} !== '0) begin
      errors++;
      $display("FAIL t6_async_reset en=%b nn=%b busy=%b crc=%h cnt=%0d rdy=%b, required all 0",
               a_en, a_nn, a_busy, a_crc, a_cnt, a_if.s_ready);
    end
    a_if.s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    snap = chain_a;
    for (int i = 0; i < LA; i++) ret.push_back(snap[LA-1-i]);
    c_exp = crc8(ret);
    for (int i = 0; i < LA / 8; i++) by.push_back(8'($urandom));
    expand(by, LA, ex);
    load_a(by, -1, 0);
    checks++; if (a_cnt !== 16'(LA) || done_a !== 1 || nn_a !== 1) begin errors++; $display("FAIL t6_reload cnt=%0d done=%0d nn=%0d required %0d 1 1", a_cnt, done_a, nn_a, LA); end
    checks++; if (diff_bits(bits_a, ex) !== 0) begin errors++; $display("FAIL t6_bits bad=%0d required 0", diff_bits(bits_a, ex)); end
    checks++; if (a_crc !== c_exp) begin errors++; $display("FAIL t6_crc got %h required %h", a_crc, c_exp); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    a_start = 1'b0; a_abort = 1'b0; b_start = 1'b0; b_abort = 1'b0;
    a_if.s_valid = 1'b0; a_if.s_data = 8'h00;
    b_if.s_valid = 1'b0; b_if.s_data = 8'h00;
    test_reset();
    test_full_load();
    test_repeat();
    test_short_chain();
    test_stall();
    test_abort();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
